pipe_reg_fd: RTL
================

Name: pipe_reg_fd

Overview:
Parametrised fetch→decode pipeline register, the successor to the single-enable fetch stall flop.
- Carries pc, instruction and pc+4 over a valid/ready handshake.
- A two-entry skid buffer keeps upstream ready registered.
- Adds flush (bubble insertion), a legacy stall input and a saturating stall-cycle counter for performance monitoring.

Parameters:
- ADDRESS_WIDTH, 32, width of pc_i/pc_o and pc_plus4_i/pc_plus4_o
- DATA_WIDTH, 32, width of instr_i/instr_o
- NOP_INSTR, 32'h0000_0013, instruction driven on instr_o whenever valid_o=0 (addi x0,x0,0)
- CNT_WIDTH, 16, width of stall_cnt_o

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  fetch presents a valid instruction
- ready_o  out  1  register can accept; registered output
- pc_i  in  ADDRESS_WIDTH  fetch pc
- instr_i  in  DATA_WIDTH  fetched instruction
- pc_plus4_i  in  ADDRESS_WIDTH  fetch pc+4
- valid_o  out  1  decode-side payload valid
- ready_i  in  1  decode can consume
- stall_i  in  1  hazard-unit stall; equivalent to ready_i=0
- flush_i  in  1  discard all held and incoming entries
- pc_o  out  ADDRESS_WIDTH  decode pc
- instr_o  out  DATA_WIDTH  decode instruction
- pc_plus4_o  out  ADDRESS_WIDTH  decode pc+4
- stall_cnt_o  out  CNT_WIDTH  cycles with valid_o=1 and no drain; saturating

Behaviour:
Definitions:
- accept = valid_i & ready_o
- drain = valid_o & ready_i & ~stall_i
- Storage: main entry (drives outputs) and skid entry.

Reset (rst_i=1 at posedge):
- state EMPTY; valid_o=0; ready_o=1.
- pc_o=0, pc_plus4_o=0, instr_o=NOP_INSTR.
- Skid cleared; stall_cnt_o=0.
- Reset overrides flush and all handshakes.

States and transitions:
- EMPTY:
  - accept → FULL, main<=input.
  - else stay.
- FULL:
  - accept & drain → FULL, main<=input.
  - accept & ~drain → SKID, skid<=input.
  - ~accept & drain → EMPTY.
  - else hold.
- SKID:
  - ready_o=0, so no accept.
  - drain → FULL, main<=skid.
  - else hold.

ready_o:
- Registered, equal to (next state != SKID).
- Never combinationally dependent on ready_i or stall_i.

Flush:
- flush_i=1 (no reset) → next state EMPTY; valid_o=0; skid invalidated; ready_o=1 next cycle.
- An input accepted in the flush cycle is discarded.
- pc_o and pc_plus4_o hold their values.
- Flush has priority over accept, drain and stall.

Output rules:
- valid_o=0 ⇒ instr_o=NOP_INSTR. pc_o and pc_plus4_o are don't-care, implemented as holding their last values.
- Payload stability: while valid_o=1 and ~drain, pc_o/instr_o/pc_plus4_o and valid_o are unchanged.
- Ordering: entries leave in acceptance order; none is dropped except by flush or reset.

Timing:
- Latency: 1 cycle from accept in EMPTY to valid_o=1.
- Throughput: 1 entry/cycle when ready_i=1 and stall_i=0.

stall_cnt_o:
- Increments by 1 on each posedge with valid_o=1 & ~drain & ~flush_i.
- Saturates at 2^CNT_WIDTH−1; no wrap.
- Cleared only by reset.

Stall/ready interaction:
- stall_i=1 with ready_i=1 behaves exactly as ready_i=0.
- stall_i with valid_o=0 has no effect.

Decomposition:
- Package pipe_pkg:
  - NOP_INSTR default constant.
  - typedef enum logic [1:0] {EMPTY, FULL, SKID} fd_state_t.
  - typedef struct packed fd_payload_t {pc, instr, pc_plus4}.
  - Widths come from package localparams matching the defaults.
- One natural sub-module: skid_buffer.
  - Generic over payload width.
  - Contains the state machine, main/skid storage and registered ready.
- pipe_reg_fd instantiates skid_buffer and adds NOP substitution, the stall_i merge, flush and stall_cnt_o.

Test Plan:
- Reset then stream: valid_i=1, pc_i=0x100/0x104/0x108, ready_i=1 → valid_o from the next cycle, pc_o=0x100,0x104,0x108 on consecutive cycles; ready_o stays 1.
- Backpressure: with pc_o=0x100 held, set ready_i=0 while pc_i=0x104 arrives → ready_o=0 next cycle. Release ready_i → pc_o=0x104 follows 0x100 with no loss or duplicate.
- Stall: stall_i=1 for 5 cycles with valid_o=1, ready_i=1 → outputs frozen at pc_o=0x200 and stall_cnt_o increases by 5.
- Flush in SKID state: flush_i=1 with valid_i=1, pc_i=0x300 → next cycle valid_o=0, instr_o=0x00000013, ready_o=1; neither 0x300 nor the skid entry ever appears.
- Counter saturation: CNT_WIDTH=4, stall 20 cycles → stall_cnt_o sticks at 15.
- Reset mid-SKID: rst_i=1 with both entries full → next cycle valid_o=0, ready_o=1, instr_o=NOP, stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch->decode pipeline register.
//   fd_state_t   : occupancy of the pipeline register (EMPTY / FULL / SKID)
//   fd_payload_t : pc, instruction and pc+4 at the default widths
//   NOP_INSTR_DEFAULT : addi x0,x0,0, shown on instr_o whenever nothing is valid
package pipe_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } fd_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus4;
  } fd_payload_t;

endpackage

// File: rtl/pipe_reg_fd_skid_buffer.sv
// Two-entry skid buffer with a registered upstream ready.
// Handshake: a word transfers upstream when valid_i & ready_o, and downstream
// when the main entry is occupied & ready_i, both on the same posedge.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : empty the buffer, discarding any word offered this cycle
//   valid_i/ready_o/data_i : upstream side (ready_o is a flop)
//   ready_i       : downstream can consume the main entry
//   data_o        : main entry contents (held when empty)
//   state_o       : current occupancy, valid downstream whenever != EMPTY
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned W = 96
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output fd_state_t    state_o
);

  fd_state_t    state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         drain;

  assign accept = valid_i & ready_q;
  assign drain  = (state_q != EMPTY) & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = data_i;
        end
      end
      FULL: begin
        if (accept && drain) begin
          main_d = data_i;
        end else if (accept) begin
          state_d = SKID;
          skid_d  = data_i;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        // ready_q is low here, so nothing can be accepted.
        if (drain) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; main keeps its contents so pc stays put.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = main_q;
  assign state_o = state_q;

endmodule

// File: rtl/pipe_reg_fd.sv
// Fetch->decode pipeline register: carries pc, instruction and pc+4 through a
// two-entry skid buffer, inserts a NOP whenever nothing is valid, supports
// flush (bubble insertion) and a legacy stall, and counts stalled cycles.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i/ready_o     : fetch handshake (ready_o registered)
//   pc_i/instr_i/pc_plus4_i : fetch payload
//   valid_o/ready_i     : decode handshake
//   stall_i             : hazard stall, same effect as ready_i=0
//   flush_i             : drop everything held and offered
//   pc_o/instr_o/pc_plus4_o : decode payload
//   stall_cnt_o         : saturating count of cycles valid_o=1 without drain
module pipe_reg_fd
  import pipe_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH    = DATA_W,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int unsigned CNT_WIDTH     = CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  localparam int unsigned PW = 2 * ADDRESS_WIDTH + DATA_WIDTH;

  logic [PW-1:0]            data_in;
  logic [PW-1:0]            data_out;
  fd_state_t                state;
  logic                     ready_eff;
  logic                     valid;
  logic                     drain;
  logic [ADDRESS_WIDTH-1:0] pc_hold;
  logic [DATA_WIDTH-1:0]    instr_hold;
  logic [ADDRESS_WIDTH-1:0] pc4_hold;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  assign data_in   = {pc_i, instr_i, pc_plus4_i};
  assign ready_eff = ready_i & ~stall_i;

  skid_buffer #(.W(PW)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_in),
    .ready_i (ready_eff),
    .data_o  (data_out),
    .state_o (state)
  );

  assign {pc_hold, instr_hold, pc4_hold} = data_out;
  assign valid = (state != EMPTY);
  assign drain = valid & ready_eff;

  assign valid_o    = valid;
  assign pc_o       = pc_hold;
  assign pc_plus4_o = pc4_hold;
  assign instr_o    = valid ? instr_hold : NOP_INSTR;

  always_comb begin
    cnt_d = cnt_q;
    if (valid && !drain && !flush_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule
